// File: rtl/cordic_iter_sequencer.sv
// Iterative sequencer for one external CORDIC rotation stage: seeds x=K, y=0, angle=0,
// feeds the stage results back for ITERATIONS cycles and presents cos/sin on valid/ready.
module cordic_iter_sequencer #(
  parameter int INTEGER_WIDTH        = 2,
  parameter int DECIMAL_WIDTH        = 20,
  parameter int DATA_WIDTH           = INTEGER_WIDTH + DECIMAL_WIDTH,
  parameter int CORDIC_COUNTER_WIDTH = 4,
  parameter int ITERATIONS           = 16,
  parameter int FLOAT_DATA_WIDTH     = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clk_en,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_target,
  input  logic [FLOAT_DATA_WIDTH-1:0]     in_tag,
  output logic                            stage_clk_en,
  output logic [DATA_WIDTH-1:0]           stage_x,
  output logic [DATA_WIDTH-1:0]           stage_y,
  output logic [DATA_WIDTH-1:0]           stage_angle,
  output logic [DATA_WIDTH-1:0]           stage_target,
  output logic [CORDIC_COUNTER_WIDTH-1:0] stage_shift_value,
  output logic [DATA_WIDTH-1:0]           stage_shift_angle,
  input  logic [DATA_WIDTH-1:0]           stage_new_x,
  input  logic [DATA_WIDTH-1:0]           stage_new_y,
  input  logic [DATA_WIDTH-1:0]           stage_new_angle,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_cos,
  output logic [DATA_WIDTH-1:0]           out_sin,
  output logic [DATA_WIDTH-1:0]           out_residual,
  output logic [FLOAT_DATA_WIDTH-1:0]     out_tag
);

  localparam int CCW = CORDIC_COUNTER_WIDTH;
  localparam int DW  = DATA_WIDTH;
  // CORDIC gain 0.607253 scaled by 2^DECIMAL_WIDTH (636751 for Q2.20)
  localparam logic [DW-1:0] K_INIT = DW'(longint'(0.6072529350088813 * (2.0 ** DECIMAL_WIDTH) + 0.5));
  localparam logic [CCW-1:0] LAST_ITER = CCW'(ITERATIONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [CCW-1:0]              iter_q, iter_d;
  logic [DW-1:0]               target_q, target_d;
  logic [FLOAT_DATA_WIDTH-1:0] tag_q, tag_d;
  logic [DW-1:0]               rom_angle;

  // round(atan(2^-i) * 2^20); entries beyond ITERATIONS-1 are never addressed
  always_comb begin
    rom_angle = '0;
    case (int'(iter_q))
      0:  rom_angle = DW'(823550);
      1:  rom_angle = DW'(486170);
      2:  rom_angle = DW'(256880);
      3:  rom_angle = DW'(130396);
      4:  rom_angle = DW'(65451);
      5:  rom_angle = DW'(32757);
      6:  rom_angle = DW'(16383);
      7:  rom_angle = DW'(8192);
      8:  rom_angle = DW'(4096);
      9:  rom_angle = DW'(2048);
      10: rom_angle = DW'(1024);
      11: rom_angle = DW'(512);
      12: rom_angle = DW'(256);
      13: rom_angle = DW'(128);
      14: rom_angle = DW'(64);
      15: rom_angle = DW'(32);
      default: rom_angle = '0;
    endcase
  end

  always_comb begin
    state_d           = state_q;
    iter_d            = iter_q;
    target_d          = target_q;
    tag_d             = tag_q;
    in_ready          = 1'b0;
    out_valid         = 1'b0;
    stage_clk_en      = 1'b0;
    stage_x           = '0;
    stage_y           = '0;
    stage_angle       = '0;
    stage_shift_angle = '0;
    out_cos           = '0;
    out_sin           = '0;
    out_residual      = '0;
    out_tag           = '0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (clk_en && in_valid) begin
          target_d = in_target;
          tag_d    = in_tag;
          iter_d   = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        stage_clk_en      = clk_en;
        stage_shift_angle = rom_angle;
        if (iter_q == '0) begin
          stage_x = K_INIT;
        end else begin
          stage_x     = stage_new_x;
          stage_y     = stage_new_y;
          stage_angle = stage_new_angle;
        end
        if (clk_en) begin
          if (iter_q == LAST_ITER) state_d = S_DONE;
          else                     iter_d  = iter_q + 1'b1;
        end
      end
      S_DONE: begin
        // stage is not clocked here, so its registered results hold under backpressure
        out_valid    = 1'b1;
        out_cos      = stage_new_x;
        out_sin      = stage_new_y;
        out_residual = stage_new_angle - target_q;
        out_tag      = tag_q;
        if (clk_en && out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stage_target      = target_q;
  assign stage_shift_value = iter_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      iter_q   <= '0;
      target_q <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      target_q <= target_d;
      tag_q    <= tag_d;
    end
  end

endmodule

// File: tb/tb_cordic_iter_sequencer.sv
// Bench for cordic_iter_sequencer: a behavioural rotation stage closes the loop, results are
// checked against an independent CORDIC model and against analytic cos/sin.
module tb_cordic_iter_sequencer;

  localparam int DW = 22;
  localparam int CCW = 4;
  localparam int FDW = 32;
  localparam int TOL = 40;

  logic clk = 1'b0, reset = 1'b1, clk_en = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, stage_clk_en;
  logic [DW-1:0] in_target = '0;
  logic [FDW-1:0] in_tag = '0, out_tag;
  logic [DW-1:0] stage_x, stage_y, stage_angle, stage_target, stage_shift_angle;
  logic [CCW-1:0] stage_shift_value;
  logic [DW-1:0] stage_new_x = '0, stage_new_y = '0, stage_new_angle = '0;
  logic [DW-1:0] out_cos, out_sin, out_residual;

  int tests = 0, fails = 0;

  cordic_iter_sequencer dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_target(in_target), .in_tag(in_tag),
    .stage_clk_en(stage_clk_en), .stage_x(stage_x), .stage_y(stage_y),
    .stage_angle(stage_angle), .stage_target(stage_target),
    .stage_shift_value(stage_shift_value), .stage_shift_angle(stage_shift_angle),
    .stage_new_x(stage_new_x), .stage_new_y(stage_new_y), .stage_new_angle(stage_new_angle),
    .out_valid(out_valid), .out_ready(out_ready), .out_cos(out_cos), .out_sin(out_sin),
    .out_residual(out_residual), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // rotation stage: rotate towards the target, registered on its clock enable
  always @(posedge clk) begin
    if (stage_clk_en) begin
      if ($signed(stage_angle) < $signed(stage_target)) begin
        stage_new_x     <= stage_x - DW'($signed(stage_y) >>> stage_shift_value);
        stage_new_y     <= stage_y + DW'($signed(stage_x) >>> stage_shift_value);
        stage_new_angle <= stage_angle + stage_shift_angle;
      end else begin
        stage_new_x     <= stage_x + DW'($signed(stage_y) >>> stage_shift_value);
        stage_new_y     <= stage_y - DW'($signed(stage_x) >>> stage_shift_value);
        stage_new_angle <= stage_angle - stage_shift_angle;
      end
    end
  end

  int atan_tab [16] = '{823550, 486170, 256880, 130396, 65451, 32757, 16383, 8192,
                        4096, 2048, 1024, 512, 256, 128, 64, 32};

  function automatic void model(input logic signed [DW-1:0] t,
                                output logic signed [DW-1:0] c, s, a);
    logic signed [DW-1:0] x, y, xs, ys;
    x = 636751; y = 0; a = 0;
    for (int i = 0; i < 16; i++) begin
      xs = x >>> i; ys = y >>> i;
      if (a < t) begin x = x - ys; y = y + xs; a = a + DW'(atan_tab[i]); end
      else       begin x = x + ys; y = y - xs; a = a - DW'(atan_tab[i]); end
    end
    c = x; s = y;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input longint act, input longint exp);
    tests++;
    if (act > exp + TOL || act < exp - TOL) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d +-%0d", name, act, exp, TOL);
    end
  endtask

  // Issues one job from a negedge, optionally stalls clk_en, waits for out_valid,
  // checks the result, applies backpressure, then retires it. Returns at a negedge in IDLE.
  task automatic run_job(input logic signed [DW-1:0] t, input logic [FDW-1:0] tg,
                         input longint ecos, input longint esin,
                         input int stall_at, input int stall_len, input int bp);
    logic signed [DW-1:0] mc, ms, ma;
    logic [DW-1:0] sx, hc, hs;
    logic [CCW-1:0] sv;
    int edges;
    bit seen;
    model(t, mc, ms, ma);
    in_target = t; in_tag = tg; in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_run", in_ready, 0);
    edges = 0; seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (edges == stall_at && stall_len > 0) begin
        chk("stall_iter_at_entry", stage_shift_value, stall_at);
        sv = stage_shift_value; sx = stage_x;
        clk_en = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          edges++;
          chk("stall_stage_clk_en", stage_clk_en, 0);
          chk("stall_iter_frozen", stage_shift_value, sv);
          chk("stall_stage_x_frozen", stage_x, sx);
        end
        clk_en = 1'b1;
      end
      @(negedge clk);
      edges++;
      if (out_valid) seen = 1;
    end
    chk("out_valid_seen", seen, 1);
    chk("latency", edges, 16 + stall_len);
    chk("exact_cos", $signed(out_cos), mc);
    chk("exact_sin", $signed(out_sin), ms);
    chk("exact_residual", $signed(out_residual), longint'(ma) - longint'(t));
    chk_tol("cos", $signed(out_cos), ecos);
    chk_tol("sin", $signed(out_sin), esin);
    chk("tag", out_tag, tg);
    chk("stage_clk_en_done", stage_clk_en, 0);
    hc = out_cos; hs = out_sin;
    // a competing request during DONE must be ignored
    in_valid = (bp > 0);
    repeat (bp) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_cos_stable", out_cos, hc);
      chk("bp_sin_stable", out_sin, hs);
      chk("bp_tag_stable", out_tag, tg);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("retire_out_valid", out_valid, 0);
    chk("retire_in_ready", in_ready, 1);
  endtask

  typedef struct {
    logic signed [DW-1:0] target;
    logic [FDW-1:0]       tag;
    longint               ecos;
    longint               esin;
    int                   bp;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{target: 22'sd0,       tag: 32'h3F800000, ecos: 1048576, esin: 0,       bp: 0};
    vecs[1] = '{target: 22'sd823550,  tag: 32'h3F490FDB, ecos: 741455,  esin: 741455,  bp: 0};
    vecs[2] = '{target: -22'sd823550, tag: 32'hBF490FDB, ecos: 741455,  esin: -741455, bp: 0};
    vecs[3] = '{target: 22'sd549033,  tag: 32'h3F060A92, ecos: 908093,  esin: 524288,  bp: 10};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stage_clk_en", stage_clk_en, 0);
    chk("rst_shift_value", stage_shift_value, 0);
    chk("rst_shift_angle", stage_shift_angle, 0);
    chk("rst_stage_target", stage_target, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_cos", out_cos, 0);

    for (int i = 0; i < 4; i++)
      run_job(vecs[i].target, vecs[i].tag, vecs[i].ecos, vecs[i].esin, -1, 0, vecs[i].bp);

    // clk_en held low for 5 cycles at iteration 7
    run_job(22'sd549033, 32'h12345678, 908093, 524288, 7, 5, 0);

    // reset at iteration 9 aborts the job
    in_target = 22'sd823550; in_tag = 32'hDEADBEEF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_reset_iter", stage_shift_value, 9);
    chk("pre_reset_stage_clk_en", stage_clk_en, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_stage_clk_en", stage_clk_en, 0);
    chk("abort_out_tag", out_tag, 0);
    repeat (3) @(negedge clk);
    chk("abort_still_idle", out_valid, 0);
    run_job(-22'sd823550, 32'hCAFEF00D, 741455, -741455, -1, 0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
